// File: rtl/npu_layer_sequencer.sv
// Layer-pass sequencer: loads A from RAM, runs the systolic array, applies leaky ReLU
// (plus rounding right-shift normalization when NPU_NORM_EN is defined), stores the result.
module npu_layer_sequencer #(
  parameter int N              = 10,
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 16,
  parameter int IN_BASE        = 0,
  parameter int OUT_BASE       = 256,
  parameter int LEAKY_SHIFT    = 3,
  parameter int NORM_SHIFT     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_button,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic                       mem_rd_en,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       mem_wr_en,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic                       sa_start,
  output logic [N*N*DATA_W-1:0]      sa_a_flat,
  input  logic                       sa_done,
  input  logic [N*N*DATA_W-1:0]      sa_result_flat
);

  localparam int NN     = N * N;
  localparam int CNT_W  = $clog2(NN + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RND_SH = (NORM_SHIFT > 0) ? NORM_SHIFT - 1 : 0;

  localparam logic [ADDR_W-1:0] IN_BASE_A  = ADDR_W'(IN_BASE);
  localparam logic [ADDR_W-1:0] OUT_BASE_A = ADDR_W'(OUT_BASE);
  localparam logic [DATA_W:0]   NORM_RND   = (NORM_SHIFT > 0) ? (DATA_W+1)'(1 << RND_SH) : '0;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_MAC_START, S_MAC_WAIT, S_ACT, S_NORM, S_STORE, S_DONE, S_ERROR
  } state_t;

  typedef logic signed [DATA_W-1:0] elem_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TO_W-1:0]   tmr_q, tmr_d;
  logic              start_prev_q;
  logic              start_edge;
  elem_t             a_q [NN];
  elem_t             a_d [NN];
  elem_t             r_q [NN];
  elem_t             r_d [NN];

  // Arithmetic shift floors toward -inf, so small negatives stay at -1.
  function automatic elem_t leaky(input elem_t x);
    return x[DATA_W-1] ? (x >>> LEAKY_SHIFT) : x;
  endfunction

  // Round-half-up shift; the extra sign bit keeps x + rounding from wrapping.
  function automatic elem_t norm(input elem_t x);
    logic signed [DATA_W:0] s;
    logic signed [DATA_W:0] sh;
    s  = $signed({x[DATA_W-1], x} + NORM_RND);
    sh = s >>> NORM_SHIFT;
    return sh[DATA_W-1:0];
  endfunction

  assign start_edge = start_button & ~start_prev_q;

  always_comb begin
    sa_a_flat = '0;
    for (int i = 0; i < NN; i++) sa_a_flat[i*DATA_W +: DATA_W] = a_q[i];
  end

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no branch infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmr_d     = tmr_q;
    a_d       = a_q;
    r_d       = r_q;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    mem_addr  = '0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_wdata = '0;
    sa_start  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end

      S_LOAD: begin
        busy      = 1'b1;
        mem_rd_en = (cnt_q < CNT_W'(NN));
        mem_addr  = IN_BASE_A + ADDR_W'(cnt_q);
        // Read data lags the strobe by one cycle, so cycle k captures element k-1.
        for (int i = 0; i < NN; i++) begin
          if (cnt_q == CNT_W'(i + 1)) a_d[i] = mem_rdata;
        end
        if (cnt_q == CNT_W'(NN)) begin
          state_d = S_MAC_START;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_MAC_START: begin
        busy     = 1'b1;
        sa_start = 1'b1;
        tmr_d    = '0;
        state_d  = S_MAC_WAIT;
      end

      S_MAC_WAIT: begin
        busy  = 1'b1;
        tmr_d = tmr_q + TO_W'(1);
        if (sa_done) begin
          for (int i = 0; i < NN; i++) r_d[i] = sa_result_flat[i*DATA_W +: DATA_W];
          state_d = S_ACT;
        end else if (tmr_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_ERROR;
        end
      end

      S_ACT: begin
        busy = 1'b1;
        for (int i = 0; i < NN; i++) r_d[i] = leaky(r_q[i]);
        cnt_d = '0;
`ifdef NPU_NORM_EN
        state_d = S_NORM;
`else
        state_d = S_STORE;
`endif
      end

`ifdef NPU_NORM_EN
      S_NORM: begin
        busy = 1'b1;
        for (int i = 0; i < NN; i++) r_d[i] = norm(r_q[i]);
        cnt_d   = '0;
        state_d = S_STORE;
      end
`endif

      S_STORE: begin
        busy      = 1'b1;
        mem_wr_en = 1'b1;
        mem_addr  = OUT_BASE_A + ADDR_W'(cnt_q);
        for (int i = 0; i < NN; i++) begin
          if (cnt_q == CNT_W'(i)) mem_wdata = r_q[i];
        end
        if (cnt_q == CNT_W'(NN - 1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      S_ERROR: begin
        err = 1'b1;
        if (start_edge) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Previous-button register resets high so a button held through reset is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      tmr_q        <= '0;
      start_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tmr_q        <= tmr_d;
      start_prev_q <= start_button;
    end
  end

  // NOTE: matrix buffers carry no reset; every element is written before it is read.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    r_q <= r_d;
  end

endmodule

// File: tb/tb_npu_layer_sequencer.sv
// Directed bench for npu_layer_sequencer with N=2, a registered RAM model and an echoing
// systolic-array model; expected outputs follow NPU_NORM_EN when it is defined.
module tb_npu_layer_sequencer;

  localparam int N  = 2;
  localparam int NN = 4;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int TO = 16;
`ifdef NPU_NORM_EN
  localparam int NE = 1;
  int exp1 [4] = '{25, 0, 0, 0};
  int exp2 [4] = '{-3, 2, -1024, 8192};
`else
  localparam int NE = 0;
  int exp1 [4] = '{100, -1, -1, 0};
  int exp2 [4] = '{-13, 7, -4096, 32767};
`endif

  logic [15:0] data1 [4] = '{16'd100, -16'sd8, -16'sd1, 16'd0};
  logic [15:0] data2 [4] = '{-16'sd100, 16'd7, 16'h8000, 16'h7fff};

  logic              clk = 1'b0;
  logic              rst;
  logic              start_button;
  logic              busy, done, err;
  logic [AW-1:0]     mem_addr;
  logic              mem_rd_en, mem_wr_en;
  logic [DW-1:0]     mem_rdata = '0;
  logic [DW-1:0]     mem_wdata;
  logic              sa_start;
  logic [NN*DW-1:0]  sa_a_flat;
  logic              sa_done;
  logic [NN*DW-1:0]  sa_res = '0;

  int total = 0;
  int bad   = 0;

  npu_layer_sequencer #(
    .N(N), .DATA_W(DW), .ADDR_W(AW), .IN_BASE(0), .OUT_BASE(256),
    .LEAKY_SHIFT(3), .NORM_SHIFT(2), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .start_button(start_button),
    .busy(busy), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
    .sa_start(sa_start), .sa_a_flat(sa_a_flat),
    .sa_done(sa_done), .sa_result_flat(sa_res)
  );

  always #5 clk = ~clk;

  // RAM model: registered read, write on the strobe edge.
  logic [15:0] ram [0:511];
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= ram[mem_addr[8:0]];
    if (mem_wr_en) ram[mem_addr[8:0]] <= mem_wdata;
  end

  // Array model: echoes A, raising sa_done on the sa_delay-th cycle after sa_start.
  int sa_delay = 5;
  bit sa_never = 1'b0;
  bit sa_act   = 1'b0;
  int sa_cnt   = 0;
  assign sa_done = sa_act && !sa_never && (sa_cnt == sa_delay);
  always @(posedge clk) begin
    if (sa_start) begin
      sa_act <= 1'b1;
      sa_cnt <= 1;
      sa_res <= sa_a_flat;
    end else if (sa_act) begin
      if (sa_done) sa_act <= 1'b0;
      else         sa_cnt <= sa_cnt + 1;
    end
  end

  int n_rd, n_wr, n_sa, n_done, n_err;
  logic [15:0] rd_addrs [$];
  always @(negedge clk) begin
    if (mem_rd_en) begin
      n_rd++;
      rd_addrs.push_back(mem_addr);
    end
    if (mem_wr_en) n_wr++;
    if (sa_start)  n_sa++;
    if (done)      n_done++;
    if (err)       n_err++;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    n_rd = 0; n_wr = 0; n_sa = 0; n_done = 0; n_err = 0;
    rd_addrs.delete();
  endtask

  task automatic preload(input logic [15:0] d [4]);
    for (int i = 0; i < 4; i++) begin
      ram[i]       <= d[i];
      ram[256 + i] <= 16'h7777;
    end
  endtask

  task automatic press();
    start_button = 1'b0;
    tick(1);
    start_button = 1'b1;
  endtask

  // Counts cycles after the current one until done is seen; -1 if the budget expires.
  task automatic wait_done(input int budget, input bit toggle_store, output int lat);
    int tg;
    tg  = 0;
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (tg == 1) begin
        start_button = 1'b1;
        tg = 2;
      end else if (toggle_store && tg == 0 && mem_wr_en) begin
        start_button = 1'b0;
        tg = 1;
      end
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic check_out(input string tag, input int e [4]);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_r%0d", tag, i), longint'($signed(ram[256 + i])), e[i]);
  endtask

  initial begin
    int lat;
    int w;
    bit seen;
    rst = 1'b1;
    start_button = 1'b1;
    for (int i = 0; i < 512; i++) ram[i] <= '0;
    clear_mon();
    tick(3);

    // Reset state with the button held high.
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_sa_start", sa_start, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);

    rst = 1'b0;
    tick(10);
    check("held_no_start", n_rd + n_sa, 0);
    check("held_busy", busy, 0);

    // Basic pass, start toggled during STORE.
    preload(data1);
    sa_never = 1'b0;
    sa_delay = 5;
    tick(1);
    clear_mon();
    press();
    @(negedge clk);
    wait_done(100, 1'b1, lat);
    check("p1_latency", lat, 17 + NE);
    tick(3);
    start_button = 1'b0;
    tick(2);
    check("p1_reads", n_rd, 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("p1_rd_addr%0d", i), (i < rd_addrs.size()) ? longint'(rd_addrs[i]) : -1, i);
    check("p1_sa_start", n_sa, 1);
    check("p1_writes", n_wr, 4);
    check("p1_done", n_done, 1);
    check_out("p1", exp1);

    // Timeout into ERROR.
    preload(data1);
    sa_never = 1'b1;
    tick(1);
    clear_mon();
    press();
    seen = 1'b0;
    w = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!seen && sa_start) begin
        seen = 1'b1;
        w = 0;
      end else if (seen) begin
        w++;
        if (err) break;
      end
    end
    check("to_cycles", w, TO + 1);
    tick(3);
    check("to_err", err, 1);
    check("to_busy", busy, 0);
    check("to_strobes", {mem_rd_en, mem_wr_en, sa_start}, 0);
    check("to_writes", n_wr, 0);
    check("to_done", n_done, 0);

    // Restart from ERROR with new data.
    preload(data2);
    sa_never = 1'b0;
    sa_delay = 5;
    tick(1);
    clear_mon();
    press();
    @(negedge clk);
    check("rs_err_edge_cycle", err, 1);
    @(negedge clk);
    check("rs_err_clear", err, 0);
    check("rs_busy", busy, 1);
    check("rs_rd_en", mem_rd_en, 1);
    check("rs_addr", mem_addr, 0);
    wait_done(100, 1'b0, lat);
    check("rs_latency", lat, 16 + NE);
    start_button = 1'b0;
    tick(2);
    check("rs_done", n_done, 1);
    check_out("rs", exp2);

    // Reset in MAC_WAIT.
    preload(data1);
    sa_delay = 5;
    tick(1);
    clear_mon();
    press();
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sa_start) begin
        seen = 1'b1;
        break;
      end
    end
    check("mr_reach_wait", seen, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mr_busy", busy, 0);
    check("mr_strobes", {mem_rd_en, mem_wr_en, sa_start, done, err}, 0);
    check("mr_addr", mem_addr, 0);
    rst = 1'b0;
    tick(12);
    check("mr_writes", n_wr, 0);
    check("mr_done", n_done, 0);
    start_button = 1'b0;

    // sa_done on the timeout cycle.
    preload(data1);
    sa_delay = TO;
    tick(1);
    clear_mon();
    press();
    @(negedge clk);
    wait_done(200, 1'b0, lat);
    check("co_latency", lat, 12 + TO + NE);
    start_button = 1'b0;
    tick(2);
    check("co_err", n_err, 0);
    check("co_done", n_done, 1);
    check("co_writes", n_wr, 4);
    check_out("co", exp1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
